// File: rtl/pipeline_ctrl.sv
// Pipeline controller for the IF/ID/EX/MEM/WB core: per-stage valid tracking,
// load-use stall, taken-branch squash, EX operand forwarding and perf counters.
module pipeline_ctrl #(
    parameter int NUM_STAGES   = 5,
    parameter int REG_ADDR_W   = 5,
    parameter int BRANCH_STAGE = 3,
    parameter int CNT_W        = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  inst_valid_in,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_uses_rt,
    input  logic [REG_ADDR_W-1:0] ex_rs,
    input  logic [REG_ADDR_W-1:0] ex_rt,
    input  logic                  ex_mem_read,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  mem_reg_write,
    input  logic [REG_ADDR_W-1:0] mem_rd,
    input  logic                  wb_reg_write,
    input  logic [REG_ADDR_W-1:0] wb_rd,
    input  logic                  branch_taken,
    input  logic                  cnt_clear,
    output logic                  pc_write,
    output logic                  if_id_write,
    output logic [NUM_STAGES-1:0] flush,
    output logic [1:0]            fwd_a,
    output logic [1:0]            fwd_b,
    output logic [NUM_STAGES-1:0] stage_valid,
    output logic                  retire,
    output logic [CNT_W-1:0]      cnt_cycles,
    output logic [CNT_W-1:0]      cnt_retired,
    output logic [CNT_W-1:0]      cnt_stalls,
    output logic [CNT_W-1:0]      cnt_flushes
);

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b01;

    logic [NUM_STAGES-1:0] stage_valid_q, stage_valid_d;
    logic [CNT_W-1:0]      cnt_cycles_q, cnt_cycles_d;
    logic [CNT_W-1:0]      cnt_retired_q, cnt_retired_d;
    logic [CNT_W-1:0]      cnt_stalls_q, cnt_stalls_d;
    logic [CNT_W-1:0]      cnt_flushes_q, cnt_flushes_d;

    logic stall;
    logic bt;
    logic rs_hazard;
    logic rt_hazard;

    always_comb begin
        rs_hazard = (ex_rd == id_rs);
        rt_hazard = id_uses_rt && (ex_rd == id_rt);
        stall     = stage_valid_q[2] && stage_valid_q[1] && ex_mem_read &&
                    (ex_rd != '0) && (rs_hazard || rt_hazard);
        bt        = branch_taken && stage_valid_q[BRANCH_STAGE];
    end

    // A taken branch wins over a stall: the stalled instruction is younger
    // than the branch and gets squashed anyway.
    always_comb begin
        stage_valid_d = {stage_valid_q[NUM_STAGES-2:0], inst_valid_in};
        pc_write      = 1'b1;
        if_id_write   = 1'b1;
        flush         = '0;
        if (bt) begin
            for (int i = 1; i <= BRANCH_STAGE; i++) begin
                flush[i]         = 1'b1;
                stage_valid_d[i] = 1'b0;
            end
        end else if (stall) begin
            pc_write         = 1'b0;
            if_id_write      = 1'b0;
            flush[2]         = 1'b1;
            stage_valid_d[0] = stage_valid_q[0];
            stage_valid_d[1] = stage_valid_q[1];
            stage_valid_d[2] = 1'b0;
        end
    end

    // MEM result is younger than WB, so it takes priority; r0 never forwards.
    always_comb begin
        fwd_a = FWD_RF;
        fwd_b = FWD_RF;
        if (stage_valid_q[2]) begin
            if (stage_valid_q[3] && mem_reg_write && (mem_rd != '0) && (mem_rd == ex_rs)) begin
                fwd_a = FWD_MEM;
            end else if (stage_valid_q[4] && wb_reg_write && (wb_rd != '0) && (wb_rd == ex_rs)) begin
                fwd_a = FWD_WB;
            end
            if (stage_valid_q[3] && mem_reg_write && (mem_rd != '0) && (mem_rd == ex_rt)) begin
                fwd_b = FWD_MEM;
            end else if (stage_valid_q[4] && wb_reg_write && (wb_rd != '0) && (wb_rd == ex_rt)) begin
                fwd_b = FWD_WB;
            end
        end
    end

    always_comb begin
        cnt_cycles_d  = cnt_cycles_q + CNT_W'(1);
        cnt_retired_d = cnt_retired_q;
        cnt_stalls_d  = cnt_stalls_q;
        cnt_flushes_d = cnt_flushes_q;
        if (stage_valid_q[NUM_STAGES-1]) begin
            cnt_retired_d = cnt_retired_q + CNT_W'(1);
        end
        if (stall && !bt) begin
            cnt_stalls_d = cnt_stalls_q + CNT_W'(1);
        end
        if (bt) begin
            cnt_flushes_d = cnt_flushes_q + CNT_W'(1);
        end
        if (cnt_clear) begin
            cnt_cycles_d  = '0;
            cnt_retired_d = '0;
            cnt_stalls_d  = '0;
            cnt_flushes_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stage_valid_q <= '0;
            cnt_cycles_q  <= '0;
            cnt_retired_q <= '0;
            cnt_stalls_q  <= '0;
            cnt_flushes_q <= '0;
        end else begin
            stage_valid_q <= stage_valid_d;
            cnt_cycles_q  <= cnt_cycles_d;
            cnt_retired_q <= cnt_retired_d;
            cnt_stalls_q  <= cnt_stalls_d;
            cnt_flushes_q <= cnt_flushes_d;
        end
    end

    assign stage_valid = stage_valid_q;
    assign retire      = stage_valid_q[NUM_STAGES-1];
    assign cnt_cycles  = cnt_cycles_q;
    assign cnt_retired = cnt_retired_q;
    assign cnt_stalls  = cnt_stalls_q;
    assign cnt_flushes = cnt_flushes_q;

endmodule
